alu_cmp_seq: RTL and testbench
==============================

Name: alu_cmp_seq

Overview:
Parametrised, multi-cycle successor to the single-cycle ALU compare stage. It latches two WIDTH-bit operands and a 3-bit compare function, then computes A−B over several cycles, CHUNK bits per cycle, LSB chunk first. It produces Z/N/V/C flags and the 1-bit compare result S, and adds the unsigned compares (LTU/GEU) that the single-cycle version lacks. It sits between the decode/issue logic and writeback, using valid/ready handshakes on both sides.

Parameters:
WIDTH, 32, operand width in bits; must be a positive multiple of CHUNK.
CHUNK, 8, bits processed per RUN cycle; NCH = WIDTH/CHUNK, where NCH ≥ 1.

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous abort of any in-flight operation
in_valid  input  1  operands/function valid
in_ready  output  1  block can accept; equals (state==IDLE)
a  input  WIDTH  operand A
b  input  WIDTH  operand B
alufun  input  3  compare function code
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
s  output  1  compare result
z  output  1  A==B
n  output  1  sign of A−B
v  output  1  signed overflow of A−B
c  output  1  carry out of A+~B+1 (1 = no borrow, A≥B unsigned)
busy  output  1  state != IDLE

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, chunk counter=0.
  - out_valid, s, z, n, v, c, busy all = 0.
  - in_ready = 1, because it is derived from state.
- FSM states: IDLE, RUN, DONE.
  - IDLE: on in_valid & in_ready (cycle T), latch a, b and alufun; set carry=1, diff-zero accumulator=1, A-zero accumulator=1, counter=0; go to RUN.
  - RUN: each cycle, process chunk k = counter.
    - {cy, d_k} = a_k + ~b_k + carry.
    - Accumulate (d_k==0) and (a_k==0).
    - Store d_k's MSB when k = NCH−1.
    - Increment counter.
    - After chunk NCH−1, go to DONE and register the flags and s.
  - DONE: out_valid = 1. When out_ready is high, go to IDLE; in_ready rises the following cycle.
- Latency: out_valid is first high at cycle T+NCH+1. Minimum issue interval is NCH+2 cycles. With CHUNK=WIDTH, latency is 2.
- Flags (D = A−B):
  - z = all diff chunks zero.
  - n = D[WIDTH−1].
  - c = final carry.
  - v = (A[W−1] != B[W−1]) & (D[W−1] != A[W−1]).
- alufun decode (AZ = A==0, AN = A[W−1]):
  - 000 NE: s=~z
  - 001 EQ: s=z
  - 010 LT: s=n^v
  - 011 LTU: s=~c
  - 100 GEU: s=c
  - 101 LTZ: s=AN
  - 110 LEZ: s=AN|AZ
  - 111 GTZ: s=~(AN|AZ)
- Outputs s/z/n/v/c are registered and updated only on the RUN→DONE transition. They hold their values through backpressure and into IDLE until the next completion.
- Inputs a, b and alufun are ignored outside the accept cycle. in_valid is ignored while in_ready=0.
- flush has priority over every transition:
  - Any state → IDLE next cycle; out_valid=0; counter cleared.
  - The result registers keep their prior values.
  - flush in the same cycle as an accept: the accept is dropped.
- Reset asserted mid-RUN or DONE: immediate return to reset values; the operation is lost, with no partial output.
- Counter width is clog2(NCH), minimum 1 bit. The counter must not wrap into a spurious extra chunk.

Test Plan:
1. WIDTH=32, CHUNK=8: accept a=5, b=5, alufun=001 at T → out_valid first high at T+5; s=1, z=1, c=1, n=0, v=0.
2. a=0x80000000, b=0x00000001, alufun=010 → D=0x7FFFFFFF; n=0, v=1, s=1. Repeat with alufun=000 → s=1.
3. a=0x00000001, b=0xFFFFFFFF: alufun=011 → s=1, c=0. alufun=010 → s=0. alufun=100 → s=0.
4. Zero tests:
   - a=0, alufun=110 → s=1; alufun=111 → s=0.
   - a=0x00000100, alufun=111 → s=1 (nonzero bit in chunk 1).
   - a=0xFFFFFF00, alufun=101 → s=1.
5. Backpressure: hold out_ready=0 for 3 cycles in DONE → out_valid, s and flags stable; in_ready=0; a concurrent in_valid pulse is not accepted. Raise out_ready → in_ready=1 the next cycle, and the next op is accepted.
6. Abort and reset:
   - Assert flush at T+2 → IDLE at T+3; no out_valid; the prior s is retained.
   - Drop rst_n mid-RUN → out_valid and all flags 0 immediately.
   - Re-run with CHUNK=32 → out_valid at T+2.

Source files
------------

// File: rtl/alu_cmp_seq.sv
// ============================================================================
// Module   : alu_cmp_seq
// Brief    : multi-cycle chunked A-B compare with Z/N/V/C flags and S result
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_cmp_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alufun,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             s,
  output logic             z,
  output logic             n,
  output logic             v,
  output logic             c,
  output logic             busy
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]       fun_q, fun_d;
  logic             carry_q, carry_d;
  logic             dz_q, dz_d, az_q, az_d;
  logic             a_msb_q, a_msb_d, b_msb_q, b_msb_d;
  logic             s_q, s_d, z_q, z_d, n_q, n_d, v_q, v_d, c_q, c_d;

  logic [WIDTH-1:0] w_a_nxt, w_b_nxt;
  logic [CHUNK:0]   w_sum;
  logic             w_dz, w_az, w_n, w_c, w_v, w_s;

  // Operands shift right so the active chunk always sits in the low bits.
  if (NCH > 1) begin : g_shift
    assign w_a_nxt = {{CHUNK{1'b0}}, a_q[WIDTH-1:CHUNK]};
    assign w_b_nxt = {{CHUNK{1'b0}}, b_q[WIDTH-1:CHUNK]};
  end else begin : g_noshift
    assign w_a_nxt = a_q;
    assign w_b_nxt = b_q;
  end

  assign w_sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, ~b_q[CHUNK-1:0]}
               + {{CHUNK{1'b0}}, carry_q};
  assign w_dz  = dz_q & (w_sum[CHUNK-1:0] == '0);
  assign w_az  = az_q & (a_q[CHUNK-1:0] == '0);
  assign w_n   = w_sum[CHUNK-1];
  assign w_c   = w_sum[CHUNK];
  assign w_v   = (a_msb_q != b_msb_q) & (w_n != a_msb_q);

  always_comb begin
    w_s = 1'b0;
    case (fun_q)
      3'b000:  w_s = ~w_dz;
      3'b001:  w_s = w_dz;
      3'b010:  w_s = w_n ^ w_v;
      3'b011:  w_s = ~w_c;
      3'b100:  w_s = w_c;
      3'b101:  w_s = a_msb_q;
      3'b110:  w_s = a_msb_q | w_az;
      default: w_s = ~(a_msb_q | w_az);
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    fun_d   = fun_q;
    carry_d = carry_q;
    dz_d    = dz_q;
    az_d    = az_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    s_d     = s_q;
    z_d     = z_q;
    n_d     = n_q;
    v_d     = v_q;
    c_d     = c_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          fun_d   = alufun;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
          carry_d = 1'b1;
          dz_d    = 1'b1;
          az_d    = 1'b1;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d     = w_a_nxt;
        b_d     = w_b_nxt;
        carry_d = w_c;
        dz_d    = w_dz;
        az_d    = w_az;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = S_DONE;
          s_d     = w_s;
          z_d     = w_dz;
          n_d     = w_n;
          v_d     = w_v;
          c_d     = w_c;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Abort wins over everything, including a same-cycle completion.
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      s_d     = s_q;
      z_d     = z_q;
      n_d     = n_q;
      v_d     = v_q;
      c_d     = c_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      fun_q   <= '0;
      carry_q <= 1'b0;
      dz_q    <= 1'b0;
      az_q    <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      s_q     <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      v_q     <= 1'b0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      fun_q   <= fun_d;
      carry_q <= carry_d;
      dz_q    <= dz_d;
      az_q    <= az_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      s_q     <= s_d;
      z_q     <= z_d;
      n_q     <= n_d;
      v_q     <= v_d;
      c_q     <= c_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign s = s_q;
  assign z = z_q;
  assign n = n_q;
  assign v = v_q;
  assign c = c_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_cmp_seq.sv
// ============================================================================
// Module   : tb_alu_cmp_seq
// Brief    : scoreboard bench for alu_cmp_seq (CHUNK=8 and CHUNK=32 instances)
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_cmp_seq;

  localparam int NCH = 4;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] a, b;
  logic [2:0]  alufun;
  logic        in_ready, out_valid, s, z, n, v, c, busy;
  logic [4:0]  flags;

  logic        in_valid2;
  logic [31:0] a2, b2;
  logic [2:0]  fun2;
  logic        in_ready2, out_valid2, s2, z2, n2, v2, c2, busy2;
  logic [4:0]  flags2;
  logic        flush2 = 1'b0;
  logic        out_ready2 = 1'b1;

  assign flags  = {s, z, n, v, c};
  assign flags2 = {s2, z2, n2, v2, c2};

  alu_cmp_seq #(.WIDTH(32), .CHUNK(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .a(a), .b(b), .alufun(alufun),
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .z(z), .n(n), .v(v), .c(c), .busy(busy)
  );

  alu_cmp_seq #(.WIDTH(32), .CHUNK(32)) u_c32 (
    .clk(clk), .rst_n(rst_n), .flush(flush2), .in_valid(in_valid2),
    .in_ready(in_ready2), .a(a2), .b(b2), .alufun(fun2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .s(s2), .z(z2), .n(n2), .v(v2), .c(c2), .busy(busy2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic [4:0] f;
    int         acc;
  } entry_t;
  entry_t sb[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Monitor: latency on first out_valid, stability under backpressure, flags on handshake.
  bit         seen = 1'b0;
  bit         pv = 1'b0;
  logic [4:0] pflags = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_out_valid", 1, 0);
        end else begin
          if (!seen) begin
            chk("latency", cyc, sb[0].acc + NCH);
            seen = 1'b1;
          end else if (pv) begin
            chk("hold_flags", int'(flags), int'(pflags));
          end
          if (out_ready) begin
            chk("flags", int'(flags), int'(sb[0].f));
            void'(sb.pop_front());
            seen = 1'b0;
          end
        end
      end
      pv     = out_valid && !out_ready;
      pflags = flags;
    end else begin
      pv   = 1'b0;
      seen = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] ia, input logic [31:0] ib,
                       input logic [2:0] f, input logic [4:0] ef, input bit push);
    entry_t e;
    int k;
    k = 0;
    while (!in_ready && k < 50) begin
      tick();
      k++;
    end
    if (!in_ready) chk("issue_timeout", 0, 1);
    a = ia;
    b = ib;
    alufun = f;
    in_valid = 1'b1;
    if (push) begin
      e.f = ef;
      e.acc = cyc + 1;
      sb.push_back(e);
    end
    tick();
    in_valid = 1'b0;
    a = 32'hDEAD_BEEF;
    b = 32'h1234_5678;
    alufun = 3'b111;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((sb.size() != 0 || !in_ready) && k < 100) begin
      tick();
      k++;
    end
    if (sb.size() != 0 || !in_ready) chk("drain_timeout", 0, 1);
  endtask

  task automatic run32(input logic [31:0] ia, input logic [31:0] ib,
                       input logic [2:0] f, input logic [4:0] ef);
    int k0;
    int k;
    a2 = ia;
    b2 = ib;
    fun2 = f;
    in_valid2 = 1'b1;
    k0 = cyc;
    tick();
    in_valid2 = 1'b0;
    k = 0;
    @(negedge clk);
    while (!out_valid2 && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("c32_latency", cyc, k0 + 2);
    chk("c32_flags", int'(flags2), int'(ef));
    tick();
    tick();
  endtask

  initial begin
    bit saw;
    rst_n = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    alufun = '0;
    in_valid2 = 1'b0;
    a2 = '0;
    b2 = '0;
    fun2 = '0;
    repeat (3) tick();
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_flags", int'(flags), 0);
    rst_n = 1'b1;
    tick();

    // Flags packed as {s,z,n,v,c}
    issue(32'd5,         32'd5,         3'b001, 5'b11001, 1'b1);
    drain();
    issue(32'h8000_0000, 32'h0000_0001, 3'b010, 5'b10011, 1'b1);
    issue(32'h8000_0000, 32'h0000_0001, 3'b000, 5'b10011, 1'b1);
    issue(32'h0000_0001, 32'hFFFF_FFFF, 3'b011, 5'b10000, 1'b1);
    issue(32'h0000_0001, 32'hFFFF_FFFF, 3'b010, 5'b00000, 1'b1);
    issue(32'h0000_0001, 32'hFFFF_FFFF, 3'b100, 5'b00000, 1'b1);
    issue(32'h0000_0000, 32'h0000_0000, 3'b110, 5'b11001, 1'b1);
    issue(32'h0000_0000, 32'h0000_0000, 3'b111, 5'b01001, 1'b1);
    issue(32'h0000_0100, 32'h0000_0000, 3'b111, 5'b10001, 1'b1);
    issue(32'hFFFF_FF00, 32'h0000_0000, 3'b101, 5'b10101, 1'b1);
    drain();

    // Backpressure with stray in_valid pulses while in DONE
    out_ready = 1'b0;
    issue(32'h0000_0001, 32'hFFFF_FFFF, 3'b011, 5'b10000, 1'b1);
    begin
      int k;
      k = 0;
      while (!out_valid && k < 20) begin
        tick();
        k++;
      end
      chk("bp_out_valid", int'(out_valid), 1);
    end
    a = 32'd7;
    b = 32'd7;
    alufun = 3'b001;
    in_valid = 1'b1;
    repeat (3) begin
      tick();
      chk("bp_in_ready", int'(in_ready), 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_release_in_ready", int'(in_ready), 1);
    issue(32'hFFFF_FF00, 32'h0000_0000, 3'b101, 5'b10101, 1'b1);
    drain();

    // Flush in the same cycle as an accept drops it
    in_valid = 1'b1;
    flush = 1'b1;
    tick();
    in_valid = 1'b0;
    flush = 1'b0;
    chk("flush_accept_busy", int'(busy), 0);

    // Flush mid-RUN: no result, prior flags retained
    issue(32'd9, 32'd3, 3'b000, 5'b00000, 1'b0);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy", int'(busy), 0);
    chk("flush_in_ready", int'(in_ready), 1);
    chk("flush_keep_flags", int'(flags), 5'b10101);
    saw = 1'b0;
    repeat (8) begin
      tick();
      if (out_valid) saw = 1'b1;
    end
    chk("flush_no_out_valid", int'(saw), 0);

    // Asynchronous reset mid-RUN
    issue(32'd9, 32'd3, 3'b000, 5'b00000, 1'b0);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_flags", int'(flags), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single-chunk instance
    run32(32'd5,         32'd5,         3'b001, 5'b11001);
    run32(32'hFFFF_FF00, 32'h0000_0000, 3'b101, 5'b10101);

    repeat (3) tick();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
